fdivsqrt_result_ctrl: RTL and testbench

Sequencing and result-assembly controller for the FP divide/square-root unit. It consumes the operand classification from the exception classifier (Ztype, Invalid, Denorm). Special-case results are produced directly, without the datapath. Normal cases are launched into the iterative datapath, which the block clocks for a fixed iteration count; the rounded result is then captured and presented with RISC-V fflags over a valid/ready handshake.

---
 rtl/fdivsqrt_pkg.sv | 44 ++++
 rtl/fdivsqrt_special_decode.sv | 44 ++++
 rtl/fdivsqrt_result_ctrl.sv | 134 +++++++++++++
 tb/tb_fdivsqrt_result_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fdivsqrt_pkg.sv
// Shared types and constants for the FP divide/square-root result controller.
package fdivsqrt_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned FLAGS_W = 5;

  localparam logic [2:0] ZTYPE_NORMAL  = 3'b000;
  localparam logic [2:0] ZTYPE_QNAN    = 3'b001;
  localparam logic [2:0] ZTYPE_INF     = 3'b010;
  localparam logic [2:0] ZTYPE_ZERO    = 3'b011;
  localparam logic [2:0] ZTYPE_DIVZERO = 3'b110;

  // Low two Ztype bits select the result class; bit 2 only qualifies it.
  localparam logic [1:0] ZCLS_NORMAL = 2'b00;
  localparam logic [1:0] ZCLS_QNAN   = 2'b01;
  localparam logic [1:0] ZCLS_INF    = 2'b10;
  localparam logic [1:0] ZCLS_ZERO   = 2'b11;

  localparam logic [DATA_W-1:0] CANON_QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [DATA_W-1:0] POS_INF    = 64'h7FF0_0000_0000_0000;
  localparam logic [DATA_W-1:0] NEG_INF    = 64'hFFF0_0000_0000_0000;
  localparam logic [DATA_W-1:0] POS_ZERO   = 64'h0000_0000_0000_0000;
  localparam logic [DATA_W-1:0] NEG_ZERO   = 64'h8000_0000_0000_0000;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRENORM = 2'd1,
    ST_ITER    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic               is_special;
    logic [DATA_W-1:0]  result;
    logic [FLAGS_W-1:0] flags;
  } special_t;

endpackage

// File: rtl/fdivsqrt_special_decode.sv
// Maps classifier outputs to a directly-produced special result, if any.
module fdivsqrt_special_decode
  import fdivsqrt_pkg::*;
(
  input  logic       Invalid,
  input  logic [2:0] Ztype,
  input  logic       op_type,
  input  logic       SignA,
  input  logic       SignB,
  output special_t   special_c
);

  logic div_sign;

  assign div_sign = SignA ^ SignB;

  // Priority: invalid, then QNaN, Inf, Zero; class 00 goes to the datapath.
  always_comb begin
    special_c = '0;
    if (Invalid) begin
      special_c.is_special     = 1'b1;
      special_c.result         = CANON_QNAN;
      special_c.flags[FLAG_NV] = 1'b1;
    end else begin
      unique case (Ztype[1:0])
        ZCLS_QNAN: begin
          special_c.is_special = 1'b1;
          special_c.result     = CANON_QNAN;
        end
        ZCLS_INF: begin
          special_c.is_special     = 1'b1;
          special_c.result         = (!op_type && div_sign) ? NEG_INF : POS_INF;
          special_c.flags[FLAG_DZ] = Ztype[2];
        end
        ZCLS_ZERO: begin
          special_c.is_special = 1'b1;
          special_c.result     = (op_type ? SignA : div_sign) ? NEG_ZERO : POS_ZERO;
        end
        default: special_c.is_special = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fdivsqrt_result_ctrl.sv
// Sequencer for the FP div/sqrt unit: special-case bypass, iteration control,
// result capture and valid/ready presentation.
module fdivsqrt_result_ctrl
  import fdivsqrt_pkg::*;
#(
  parameter int unsigned DIV_CYCLES  = 30,
  parameter int unsigned SQRT_CYCLES = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               start_ready,
  input  logic               op_type,
  input  logic [2:0]         Ztype,
  input  logic               Invalid,
  input  logic               Denorm,
  input  logic               SignA,
  input  logic               SignB,
  input  logic               flush,
  output logic               core_prenorm,
  output logic               core_load,
  output logic               core_en,
  input  logic [DATA_W-1:0]  core_result,
  input  logic [2:0]         core_flags,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  result,
  output logic [FLAGS_W-1:0] fflags
);

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, next_cnt;
  logic [DATA_W-1:0]  next_result;
  logic [FLAGS_W-1:0] next_fflags;
  logic               next_res_valid, next_prenorm, next_load, next_en;
  logic               accept_c;
  special_t           special_c;

  fdivsqrt_special_decode u_special_decode (
    .Invalid   (Invalid),
    .Ztype     (Ztype),
    .op_type   (op_type),
    .SignA     (SignA),
    .SignB     (SignB),
    .special_c (special_c)
  );

  assign accept_c = start & start_ready & ~flush;

  // Next-state and next-output computation; all outputs are registered below.
  always_comb begin
    next_state     = state;
    next_cnt       = cnt;
    next_result    = result;
    next_fflags    = fflags;
    next_res_valid = 1'b0;
    next_prenorm   = 1'b0;
    next_load      = 1'b0;
    next_en        = 1'b0;
    if (flush) begin
      next_state = ST_IDLE;
      next_cnt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept_c) begin
            // Counter is loaded at accept; PRENORM leaves it untouched.
            next_cnt = op_type ? CNT_W'(SQRT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            if (special_c.is_special) begin
              next_result    = special_c.result;
              next_fflags    = special_c.flags;
              next_res_valid = 1'b1;
              next_state     = ST_DONE;
            end else if (Denorm) begin
              next_prenorm = 1'b1;
              next_state   = ST_PRENORM;
            end else begin
              next_load  = 1'b1;
              next_en    = 1'b1;
              next_state = ST_ITER;
            end
          end
        end
        ST_PRENORM: begin
          next_load  = 1'b1;
          next_en    = 1'b1;
          next_state = ST_ITER;
        end
        ST_ITER: begin
          if (cnt == '0) begin
            next_result    = core_result;
            next_fflags    = {2'b00, core_flags};
            next_res_valid = 1'b1;
            next_state     = ST_DONE;
          end else begin
            next_cnt = cnt - CNT_W'(1);
            next_en  = 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) next_state     = ST_IDLE;
          else           next_res_valid = 1'b1;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      result       <= '0;
      fflags       <= '0;
      res_valid    <= 1'b0;
      start_ready  <= 1'b1;
      core_prenorm <= 1'b0;
      core_load    <= 1'b0;
      core_en      <= 1'b0;
    end else begin
      state        <= next_state;
      cnt          <= next_cnt;
      result       <= next_result;
      fflags       <= next_fflags;
      res_valid    <= next_res_valid;
      start_ready  <= (next_state == ST_IDLE);
      core_prenorm <= next_prenorm;
      core_load    <= next_load;
      core_en      <= next_en;
    end
  end

endmodule

// File: tb/tb_fdivsqrt_result_ctrl.sv
// Self-checking bench for fdivsqrt_result_ctrl: vector table plus flush and
// asynchronous reset sequences, results checked through a scoreboard queue.
module tb_fdivsqrt_result_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, start_ready, op_type, Invalid, Denorm, SignA, SignB, flush;
  logic [2:0]  Ztype;
  logic        core_prenorm, core_load, core_en;
  logic [63:0] core_result;
  logic [2:0]  core_flags;
  logic        res_valid, res_ready;
  logic [63:0] result;
  logic [4:0]  fflags;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        op;
    logic [2:0]  z;
    logic        inv, den, sa, sb;
    logic [63:0] cr;
    logic [2:0]  cf;
    logic [63:0] er;
    logic [4:0]  ef;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [63:0] r;
    logic [4:0]  f;
  } exp_t;

  vec_t vecs[12];
  exp_t sb_q[$];

  fdivsqrt_result_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_ready  (start_ready),
    .op_type      (op_type),
    .Ztype        (Ztype),
    .Invalid      (Invalid),
    .Denorm       (Denorm),
    .SignA        (SignA),
    .SignB        (SignB),
    .flush        (flush),
    .core_prenorm (core_prenorm),
    .core_load    (core_load),
    .core_en      (core_en),
    .core_result  (core_result),
    .core_flags   (core_flags),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .result       (result),
    .fflags       (fflags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic op, input logic [2:0] z, input logic inv,
                           input logic den, input logic sa, input logic sb,
                           input logic [63:0] cr, input logic [2:0] cf);
    op_type = op; Ztype = z; Invalid = inv; Denorm = den;
    SignA = sa; SignB = sb; core_result = cr; core_flags = cf;
    start = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s_queue: got empty scoreboard expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_result"}, result, e.r);
      check({tag, "_fflags"}, 64'(fflags), 64'(e.f));
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc, n_en, n_ld, n_pn, ld_at, n_iter;
    logic normal;
    logic [63:0] held;
    string tag;
    tag    = $sformatf("vec%0d", idx);
    normal = (v.z[1:0] == 2'b00) && !v.inv;
    n_iter = v.op ? 32 : 30;
    @(negedge clk);
    res_ready = 1'b0;
    drive_req(v.op, v.z, v.inv, v.den, v.sa, v.sb, v.cr, v.cf);
    sb_q.push_back('{v.er, v.ef});
    @(negedge clk);
    start = 1'b0;
    cyc = 1; n_en = 0; n_ld = 0; n_pn = 0; ld_at = 0;
    while (!res_valid && cyc < 200) begin
      if (core_en) n_en++;
      if (core_load) begin n_ld++; ld_at = cyc; end
      if (core_prenorm) n_pn++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(v.lat));
    check({tag, "_en_cycles"}, 64'(n_en), normal ? 64'(n_iter) : 64'd0);
    check({tag, "_load_count"}, 64'(n_ld), normal ? 64'd1 : 64'd0);
    check({tag, "_prenorm_count"}, 64'(n_pn), (normal && v.den) ? 64'd1 : 64'd0);
    if (normal) check({tag, "_load_cycle"}, 64'(ld_at), v.den ? 64'd2 : 64'd1);
    pop_check(tag);
    held = result;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_hold_result"}, result, held);
      check({tag, "_hold_start_ready"}, 64'(start_ready), 64'd0);
      check({tag, "_hold_core_en"}, 64'(core_en), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_post_start_ready"}, 64'(start_ready), 64'd1);
    check({tag, "_post_result"}, result, v.er);
  endtask

  initial begin
    logic [63:0] prev_result;
    //            op    z       inv   den   sa    sb    core_result             cf      exp_result              ef        lat hold
    vecs[0]  = '{1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                 3'b000, 64'hFFF0000000000000, 5'b01000, 1,  0};
    vecs[1]  = '{1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                 3'b000, 64'h8000000000000000, 5'b00000, 1,  2};
    vecs[2]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 3'b000, 64'h7FF8000000000000, 5'b10000, 1,  0};
    vecs[3]  = '{1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0,                 3'b000, 64'h7FF8000000000000, 5'b00000, 1,  0};
    vecs[4]  = '{1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0,                 3'b000, 64'h7FF0000000000000, 5'b00000, 1,  0};
    vecs[5]  = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                 3'b000, 64'h7FF0000000000000, 5'b00000, 1,  0};
    vecs[6]  = '{1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0,                 3'b000, 64'h8000000000000000, 5'b00000, 1,  0};
    vecs[7]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF8000000000000, 3'b001, 64'h3FF8000000000000, 5'b00001, 31, 0};
    vecs[8]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h3FF8000000000000, 3'b001, 64'h3FF8000000000000, 5'b00001, 32, 0};
    vecs[9]  = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF6A09E667F3BCD, 3'b101, 64'h3FF6A09E667F3BCD, 5'b00101, 33, 5};
    vecs[10] = '{1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0010000000000000, 3'b010, 64'h0010000000000000, 5'b00010, 34, 0};
    vecs[11] = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,                 3'b000, 64'h7FF8000000000000, 5'b10000, 1,  0};

    reset_n = 1'b0; start = 1'b0; op_type = 1'b0; Ztype = 3'b000; Invalid = 1'b0;
    Denorm = 1'b0; SignA = 1'b0; SignB = 1'b0; flush = 1'b0; core_result = '0;
    core_flags = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_fflags", 64'(fflags), 64'd0);
    check("rst_core", 64'({core_prenorm, core_load, core_en}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_start_ready", 64'(start_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Flush during iteration cycle 10 with a competing start request.
    prev_result = result;
    @(negedge clk);
    drive_req(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h4000000000000000, 3'b001);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    check("flush_pre_core_en", 64'(core_en), 64'd1);
    flush = 1'b1;
    drive_req(1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 3'b000);
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", 64'(res_valid), 64'd0);
    check("flush_core_en", 64'(core_en), 64'd0);
    check("flush_core_load", 64'(core_load), 64'd0);
    check("flush_start_ready", 64'(start_ready), 64'd1);
    check("flush_result_kept", result, prev_result);
    sb_q.push_back('{64'hFFF0000000000000, 5'b01000});
    @(negedge clk);
    start = 1'b0;
    check("postflush_valid", 64'(res_valid), 64'd1);
    pop_check("postflush");
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("postflush_idle", 64'(start_ready), 64'd1);

    // Asynchronous reset in the middle of an iteration.
    @(negedge clk);
    drive_req(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h1234, 3'b001);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("areset_pre_core_en", 64'(core_en), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("areset_core_en", 64'(core_en), 64'd0);
    check("areset_result", result, 64'd0);
    check("areset_fflags", 64'(fflags), 64'd0);
    check("areset_start_ready", 64'(start_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("areset_no_valid", 64'(res_valid), 64'd0);
    check("areset_idle_core_en", 64'(core_en), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
